// File: rtl/pipeline_acc_ctrl_if.sv
// pipeline_acc_ctrl_if
// Bundles the operand stream, the adder issue/return path and the result
// port of pipeline_acc_ctrl.
//   I_operand/I_op_rdy/I_op_last/O_op_ack : operand stream with ready/valid
//   O_add_a/O_add_b/O_add_vld/I_add_sum    : pipelined adder issue and return
//   O_result_rdy/O_result                  : one-cycle result pulse and held sum
// Modports: slave = the controller, master = the surrounding environment.
interface pipeline_acc_ctrl_if #(
  parameter int C_IN1 = 12,
  parameter int C_OUT = 13
);
  logic [C_IN1-1:0] I_operand;
  logic             I_op_rdy;
  logic             I_op_last;
  logic             O_op_ack;
  logic [C_OUT-1:0] O_add_a;
  logic [C_OUT-1:0] O_add_b;
  logic             O_add_vld;
  logic [C_OUT-1:0] I_add_sum;
  logic             O_result_rdy;
  logic [C_OUT-1:0] O_result;

  modport slave (
    input  I_operand, I_op_rdy, I_op_last, I_add_sum,
    output O_op_ack, O_add_a, O_add_b, O_add_vld, O_result_rdy, O_result
  );

  modport master (
    output I_operand, I_op_rdy, I_op_last, I_add_sum,
    input  O_op_ack, O_add_a, O_add_b, O_add_vld, O_result_rdy, O_result
  );
endinterface

// File: rtl/pipeline_acc_ctrl.sv
// pipeline_acc_ctrl
// Accumulates an operand stream through an external pipelined adder of
// latency C_ADD_LAT. One partial sum is kept per issue phase so the adder
// can take an operand every cycle; after the last operand the partials are
// folded into a single result.
// Ports:
//   I_clk   : clock
//   I_rst_n : asynchronous active-low reset
//   bus     : pipeline_acc_ctrl_if.slave (operand stream, adder, result)
//
// state    | meaning
// ---------+------------------------------------------
// S_IDLE   | no group open
// S_ACC    | group open, accepting operands
// S_REDUCE | last operand taken, folding partial sums
module pipeline_acc_ctrl #(
  parameter int C_IN1     = 12,
  parameter int C_OUT     = 13,
  parameter int C_ADD_LAT = 2
) (
  input logic             I_clk,
  input logic             I_rst_n,
  pipeline_acc_ctrl_if.slave bus
);
  localparam int C_PH_W = (C_ADD_LAT > 1) ? $clog2(C_ADD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_REDUCE} state_t;

  state_t               state;
  logic [C_PH_W-1:0]    ph;
  logic [C_ADD_LAT-1:0] vld_sr;
  logic [C_OUT-1:0]     slot [C_ADD_LAT];
  logic [C_ADD_LAT-1:0] slot_vld;
  logic [2:0]           live;
  logic                 op_ack_q;
  logic                 result_rdy_q;
  logic [C_OUT-1:0]     result_q;

  logic              ret;
  logic              accept;
  logic              part_vld;
  logic [C_OUT-1:0]  part;
  logic              oth_vld;
  logic [C_PH_W-1:0] oth_q;
  logic              combine;
  logic              finish;
  logic              issue;
  logic [C_OUT-1:0]  add_a;
  logic [C_OUT-1:0]  add_b;

  always_comb begin
    // the oldest shift-register bit marks a sum returning for the current phase
    ret      = vld_sr[C_ADD_LAT-1];
    accept   = bus.I_op_rdy & op_ack_q;
    part_vld = ret | slot_vld[ph];
    part     = ret ? bus.I_add_sum : slot[ph];
    oth_vld  = 1'b0;
    oth_q    = '0;
    // descending scan so the lowest valid slot other than ph wins
    for (int q = C_ADD_LAT - 1; q >= 0; q--) begin
      if (slot_vld[q] && (C_PH_W'(q) != ph)) begin
        oth_vld = 1'b1;
        oth_q   = C_PH_W'(q);
      end
    end
    combine = (state == S_REDUCE) && part_vld && oth_vld;
    // live counts in-flight plus slotted partials, so a return with live==1
    // is the only partial left
    finish  = (state == S_REDUCE) && ret && (live == 3'd1);
    issue   = accept | combine;
    add_a   = accept ? C_OUT'(bus.I_operand) : part;
    add_b   = accept ? (part_vld ? part : '0) : slot[oth_q];
  end

  // issue is combinational so a sum re-enters the adder in the cycle it returns
  assign bus.O_add_vld    = issue;
  assign bus.O_add_a      = issue ? add_a : '0;
  assign bus.O_add_b      = issue ? add_b : '0;
  assign bus.O_op_ack     = op_ack_q;
  assign bus.O_result_rdy = result_rdy_q;
  assign bus.O_result     = result_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state        <= S_IDLE;
      ph           <= '0;
      vld_sr       <= '0;
      slot_vld     <= '0;
      live         <= '0;
      op_ack_q     <= 1'b1;
      result_rdy_q <= 1'b0;
      result_q     <= '0;
      for (int i = 0; i < C_ADD_LAT; i++) slot[i] <= '0;
    end else begin
      ph           <= (ph == C_PH_W'(C_ADD_LAT - 1)) ? '0 : ph + 1'b1;
      vld_sr       <= C_ADD_LAT'({vld_sr, issue});
      result_rdy_q <= 1'b0;
      case (state)
        S_IDLE, S_ACC: begin
          if (accept) begin
            slot_vld[ph] <= 1'b0;
            if (!part_vld) live <= live + 3'd1;
            if (bus.I_op_last) begin
              state    <= S_REDUCE;
              op_ack_q <= 1'b0;
            end else begin
              state <= S_ACC;
            end
          end else if (ret) begin
            slot[ph]     <= bus.I_add_sum;
            slot_vld[ph] <= 1'b1;
          end
        end
        S_REDUCE: begin
          if (finish) begin
            result_q     <= bus.I_add_sum;
            result_rdy_q <= 1'b1;
            op_ack_q     <= 1'b1;
            slot_vld     <= '0;
            live         <= '0;
            state        <= S_IDLE;
          end else if (combine) begin
            slot_vld[ph]    <= 1'b0;
            slot_vld[oth_q] <= 1'b0;
            live            <= live - 3'd1;
          end else if (ret) begin
            // more partials still exist; park this one until a partner appears
            slot[ph]     <= bus.I_add_sum;
            slot_vld[ph] <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_acc_ctrl.sv
// Testbench for pipeline_acc_ctrl: one instance with adder latency 2 and one
// with latency 3, each paired with a behavioural pipelined adder. Expected
// group results are queued when a group is sent and checked by per-instance
// monitors when O_result_rdy pulses.
module tb_pipeline_acc_ctrl;
  typedef struct {
    int          id;
    logic [12:0] res;
    int          iss;
    int          lat;
    int          low;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] op    = '0;
  logic        rdy   = 1'b0;
  logic        last  = 1'b0;
  logic        sel   = 1'b0;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q2[$];
  exp_t        q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipeline_acc_ctrl_if #(.C_IN1(12), .C_OUT(13)) if2 ();
  pipeline_acc_ctrl_if #(.C_IN1(12), .C_OUT(13)) if3 ();

  pipeline_acc_ctrl #(.C_IN1(12), .C_OUT(13), .C_ADD_LAT(2)) dut2 (
    .I_clk(clk), .I_rst_n(rst_n), .bus(if2));
  pipeline_acc_ctrl #(.C_IN1(12), .C_OUT(13), .C_ADD_LAT(3)) dut3 (
    .I_clk(clk), .I_rst_n(rst_n), .bus(if3));

  assign if2.I_operand = op;
  assign if2.I_op_last = last;
  assign if2.I_op_rdy  = rdy & ~sel;
  assign if3.I_operand = op;
  assign if3.I_op_last = last;
  assign if3.I_op_rdy  = rdy & sel;

  // behavioural pipelined adders, not reset, carrying no valid
  logic [12:0] p2 [2];
  logic [12:0] p3 [3];
  always @(posedge clk) begin
    p2[0] <= if2.O_add_a + if2.O_add_b;
    p2[1] <= p2[0];
    p3[0] <= if3.O_add_a + if3.O_add_b;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if2.I_add_sum = p2[1];
  assign if3.I_add_sum = p3[2];

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void check_pulse(input string t, input exp_t e, input logic [12:0] res,
                                      input int iss, input int lat, input int low, input logic ack);
    chk($sformatf("%s_g%0d_result", t, e.id), int'(res), int'(e.res));
    chk($sformatf("%s_g%0d_issues", t, e.id), iss, e.iss);
    chk($sformatf("%s_g%0d_latency", t, e.id), lat, e.lat);
    chk($sformatf("%s_g%0d_ack_low_cycles", t, e.id), low, e.low);
    chk($sformatf("%s_g%0d_ack_at_pulse", t, e.id), int'(ack), 1);
  endfunction

  function automatic void push(input logic d3, input int id, input int res, input int iss,
                               input int lat, input int low);
    exp_t e;
    e.id = id; e.res = 13'(res); e.iss = iss; e.lat = lat; e.low = low;
    if (d3) q3.push_back(e);
    else    q2.push_back(e);
  endfunction

  // monitor state per instance
  int iss2 = 0, low2 = 0, st2 = 0, pend2 = 0;
  int iss3 = 0, low3 = 0, st3 = 0, pend3 = 0;
  logic in2 = 1'b0, in3 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      iss2 = 0; low2 = 0; in2 = 1'b0;
    end else begin
      if (if2.O_result_rdy) begin
        chk("l2_pulse_expected", int'(q2.size() > 0), 1);
        if (q2.size() > 0)
          check_pulse("l2", q2.pop_front(), if2.O_result, iss2, cyc - pend2, low2, if2.O_op_ack);
        iss2 = 0; low2 = 0;
      end else if (!if2.O_op_ack) begin
        low2++;
      end
      if (if2.O_add_vld) iss2++;
      if (if2.I_op_rdy && if2.O_op_ack) begin
        if (!in2) begin st2 = cyc; in2 = 1'b1; end
        if (if2.I_op_last) begin pend2 = st2; in2 = 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      iss3 = 0; low3 = 0; in3 = 1'b0;
    end else begin
      if (if3.O_result_rdy) begin
        chk("l3_pulse_expected", int'(q3.size() > 0), 1);
        if (q3.size() > 0)
          check_pulse("l3", q3.pop_front(), if3.O_result, iss3, cyc - pend3, low3, if3.O_op_ack);
        iss3 = 0; low3 = 0;
      end else if (!if3.O_op_ack) begin
        low3++;
      end
      if (if3.O_add_vld) iss3++;
      if (if3.I_op_rdy && if3.O_op_ack) begin
        if (!in3) begin st3 = cyc; in3 = 1'b1; end
        if (if3.I_op_last) begin pend3 = st3; in3 = 1'b0; end
      end
    end
  end

  // present one operand and hold it until the selected instance accepts it
  task automatic send(input int v, input logic l);
    logic a;
    int   n = 0;
    op = 12'(v); last = l; rdy = 1'b1;
    forever begin
      @(negedge clk);
      a = sel ? if3.O_op_ack : if2.O_op_ack;
      @(posedge clk);
      #1;
      if (a) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: operand %0d not accepted within 200 cycles", v);
        break;
      end
    end
    rdy = 1'b0; last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    int n = 0;
    while (((sel ? q3.size() : q2.size()) != 0) && (n < 200)) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL result_timeout: %0d results outstanding after 200 cycles",
               sel ? q3.size() : q2.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_l2",        int'(if2.O_op_ack), 1);
    chk("rst_result_rdy_l2", int'(if2.O_result_rdy), 0);
    chk("rst_result_l2",     int'(if2.O_result), 0);
    chk("rst_add_vld_l2",    int'(if2.O_add_vld), 0);
    chk("rst_ack_l3",        int'(if3.O_op_ack), 1);
    chk("rst_result_l3",     int'(if3.O_result), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1+2+3+4 back-to-back: pulse at cycle 8, ack low cycles 4..7
    push(1'b0, 1, 10, 5, 8, 4);
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b1);
    wait_done();

    // single operand: one issue, pulse at cycle 3
    push(1'b0, 2, 7, 1, 3, 2);
    send(7, 1'b1);
    wait_done();

    // bubbles: 5, -, 6, -, -, 9
    push(1'b0, 3, 20, 4, 10, 4);
    send(5, 1'b0); idle(1); send(6, 1'b0); idle(2); send(9, 1'b1);
    wait_done();

    // wrap modulo 2^13: 3*4095 = 12285 -> 4093
    push(1'b0, 4, 4093, 4, 7, 4);
    send(4095, 1'b0); send(4095, 1'b0); send(4095, 1'b1);
    wait_done();

    // abort a group with reset two cycles after its first operand
    send(100, 1'b0); send(200, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("midrst_ack_l2",        int'(if2.O_op_ack), 1);
    chk("midrst_result_l2",     int'(if2.O_result), 0);
    chk("midrst_result_rdy_l2", int'(if2.O_result_rdy), 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    push(1'b0, 5, 6, 3, 6, 4);
    send(3, 1'b0); send(3, 1'b1);
    wait_done();

    // latency 3: 1..5, then a second group held during the ack-low window
    sel = 1'b1;
    push(1'b1, 6, 15, 7, 13, 8);
    push(1'b1, 7, 30, 3, 8, 6);
    for (int i = 1; i <= 5; i++) send(i, (i == 5));
    send(10, 1'b0); send(20, 1'b1);
    wait_done();

    idle(8);
    chk("l2_queue_drained", q2.size(), 0);
    chk("l3_queue_drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
